hub75e_bcm_sched: RTL and testbench

Scan scheduler for the HUB75E panel. It replaces the free-running shift/PWM front end with binary-coded modulation (BCM) and double-buffered frame banks. The block sits between the dual-port pixel RAM (read port) and the panel pins. It sequences column shift, latch, row address and OE for each bit plane of each row pair, and swaps the display bank only at frame boundaries on request from the SPI writer.

---
 rtl/hub75e_bcm_sched.sv | 215 +++++++++++++++++++++
 tb/tb_hub75e_bcm_sched.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75e_bcm_sched.sv
// HUB75E scan scheduler: binary-coded modulation over DEPTH bit planes per
// row pair, with a double-buffered display bank swapped only at frame end.
module hub75e_bcm_sched #(
  parameter int COLS  = 64,
  parameter int ROWS  = 32,
  parameter int DEPTH = 5,
  parameter int BASE  = 8
) (
  input  logic                                   clock,
  input  logic                                   resetn,
  input  logic                                   enable,
  input  logic                                   swap_req,
  output logic                                   swap_ack,
  output logic                                   display_bank,
  output logic [$clog2(ROWS)+$clog2(COLS):0]     ram_raddr,
  input  logic [31:0]                            ram_rdata,
  output logic [5:0]                             hub_rgb,
  output logic                                   hub_ck,
  output logic                                   hub_st,
  output logic                                   hub_oe,
  output logic [$clog2(ROWS)-1:0]                hub_row,
  output logic                                   frame_start
);

  localparam int CW        = $clog2(COLS);
  localparam int RW        = $clog2(ROWS);
  localparam int AW        = 1 + RW + CW;
  localparam int PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SHIFT_LEN = 2 * COLS;
  localparam int SHOW_MAX  = BASE << (DEPTH - 1);
  localparam int CNT_MAX   = (SHIFT_LEN > SHOW_MAX) ? SHIFT_LEN : SHOW_MAX;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(SHIFT_LEN - 1);
  localparam logic [CNT_W:0]   COL_MAX    = (CNT_W + 1)'(COLS - 1);
  localparam logic [PW-1:0]    PLANE_LAST = PW'(DEPTH - 1);
  localparam logic [RW-1:0]    ROW_LAST   = RW'(ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_SHIFT,
    S_L0,
    S_L1,
    S_SHOW
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RW-1:0]    row_q, row_d;
  logic [PW-1:0]    plane_q, plane_d;
  logic             bank_q, bank_d;
  logic             pend_q, pend_d;
  logic             ack_q, ack_d;
  logic             fs_q, fs_d;
  logic             ck_q, ck_d;
  logic             st_q, st_d;
  logic             oe_q, oe_d;
  logic [RW-1:0]    hubrow_q, hubrow_d;
  logic [AW-1:0]    raddr_q, raddr_d;

  logic [CNT_W-1:0] show_last;
  logic [CNT_W:0]   col_sum;
  logic [CW-1:0]    col_d;

  logic [4:0] r1, g1, b1, r2, g2, b2;
  logic       unused_rdata;

  // Split the two RGB555 pixels of the RAM word into their colour fields
  assign b1 = ram_rdata[4:0];
  assign g1 = ram_rdata[9:5];
  assign r1 = ram_rdata[14:10];
  assign b2 = ram_rdata[20:16];
  assign g2 = ram_rdata[25:21];
  assign r2 = ram_rdata[30:26];
  assign unused_rdata = ^{ram_rdata[15], ram_rdata[31]};

  // Panel colour pins carry the active bit plane of each field straight from RAM data
  always_comb begin
    hub_rgb = {r1[plane_q], g1[plane_q], b1[plane_q],
               r2[plane_q], g2[plane_q], b2[plane_q]};
  end

  // Scan sequencer: state/counter advance, frame-end swap decision, next output values
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    row_d     = row_q;
    plane_d   = plane_q;
    bank_d    = bank_q;
    pend_d    = pend_q | swap_req;
    ack_d     = 1'b0;
    fs_d      = 1'b0;
    show_last = CNT_W'((BASE << plane_q) - 1);

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_PRE;
          fs_d    = 1'b1;
        end
      end
      S_PRE: begin
        state_d = S_SHIFT;
        cnt_d   = '0;
      end
      S_SHIFT: begin
        if (cnt_q == SHIFT_LAST) begin
          state_d = S_L0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_L0: begin
        state_d = S_L1;
      end
      S_L1: begin
        state_d = S_SHOW;
        cnt_d   = '0;
      end
      S_SHOW: begin
        if (cnt_q == show_last) begin
          cnt_d   = '0;
          state_d = S_PRE;
          if (plane_q != PLANE_LAST) begin
            plane_d = plane_q + PW'(1);
          end else begin
            plane_d = '0;
            if (row_q != ROW_LAST) begin
              row_d = row_q + RW'(1);
            end else begin
              // Frame end: a request in this very cycle still makes this boundary
              row_d  = '0;
              pend_d = 1'b0;
              if (pend_q | swap_req) begin
                bank_d = ~bank_q;
                ack_d  = 1'b1;
              end
              if (enable) begin
                fs_d = 1'b1;
              end else begin
                state_d = S_IDLE;
              end
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Column address runs one half-step ahead of the shift clock to cover RAM latency
    col_sum = ({1'b0, cnt_d} + (CNT_W + 1)'(1)) >> 1;
    col_d   = (col_sum > COL_MAX) ? CW'(COLS - 1) : CW'(col_sum);

    oe_d     = (state_d != S_SHOW);
    ck_d     = (state_d == S_SHIFT) && cnt_d[0];
    st_d     = (state_d == S_L0);
    hubrow_d = (state_d == S_L0) ? row_q : hubrow_q;

    raddr_d = raddr_q;
    if (state_d == S_PRE) begin
      raddr_d = {bank_d, row_d, {CW{1'b0}}};
    end else if (state_d == S_SHIFT) begin
      raddr_d = {bank_d, row_d, col_d};
    end
  end

  // State and registered panel/RAM outputs; reset blanks the panel at once
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      row_q    <= '0;
      plane_q  <= '0;
      bank_q   <= 1'b0;
      pend_q   <= 1'b0;
      ack_q    <= 1'b0;
      fs_q     <= 1'b0;
      ck_q     <= 1'b0;
      st_q     <= 1'b0;
      oe_q     <= 1'b1;
      hubrow_q <= '0;
      raddr_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      row_q    <= row_d;
      plane_q  <= plane_d;
      bank_q   <= bank_d;
      pend_q   <= pend_d;
      ack_q    <= ack_d;
      fs_q     <= fs_d;
      ck_q     <= ck_d;
      st_q     <= st_d;
      oe_q     <= oe_d;
      hubrow_q <= hubrow_d;
      raddr_q  <= raddr_d;
    end
  end

  assign swap_ack     = ack_q;
  assign display_bank = bank_q;
  assign ram_raddr    = raddr_q;
  assign hub_ck       = ck_q;
  assign hub_st       = st_q;
  assign hub_oe       = oe_q;
  assign hub_row      = hubrow_q;
  assign frame_start  = fs_q;

endmodule

// File: tb/tb_hub75e_bcm_sched.sv
// Bench for hub75e_bcm_sched: frame-position reference model plus directed
// and randomized scenarios (swap timing, enable drop, async reset).
module tb_hub75e_bcm_sched;

  localparam int COLS  = 16;
  localparam int ROWS  = 4;
  localparam int DEPTH = 5;
  localparam int BASE  = 2;
  localparam int CW    = $clog2(COLS);
  localparam int RW    = $clog2(ROWS);
  localparam int AW    = 1 + RW + CW;
  localparam int PLANE_FIX = 3 + 2 * COLS;
  localparam int ROW_LEN   = DEPTH * PLANE_FIX + BASE * ((1 << DEPTH) - 1);
  localparam int FRAME     = ROWS * ROW_LEN;
  localparam int PH_PRE = 0, PH_SHIFT = 1, PH_L0 = 2, PH_L1 = 3, PH_SHOW = 4;

  logic clock = 1'b0;
  logic resetn = 1'b1;
  logic enable = 1'b0;
  logic swap_req = 1'b0;
  logic swap_ack, display_bank, hub_ck, hub_st, hub_oe, frame_start;
  logic [AW-1:0] ram_raddr;
  logic [31:0]   ram_rdata;
  logic [5:0]    hub_rgb;
  logic [RW-1:0] hub_row;
  logic [31:0]   mem [0:(1<<AW)-1];

  int n_total = 0;
  int n_bad   = 0;
  bit chk_en  = 1'b0;

  // reference model: position inside the frame timeline
  bit m_run = 0, m_bank = 0, m_pend = 0, m_ack = 0, m_fs = 0;
  int m_t = 0, m_row = 0;

  hub75e_bcm_sched #(.COLS(COLS), .ROWS(ROWS), .DEPTH(DEPTH), .BASE(BASE)) dut (
    .clock(clock), .resetn(resetn), .enable(enable), .swap_req(swap_req),
    .swap_ack(swap_ack), .display_bank(display_bank), .ram_raddr(ram_raddr),
    .ram_rdata(ram_rdata), .hub_rgb(hub_rgb), .hub_ck(hub_ck), .hub_st(hub_st),
    .hub_oe(hub_oe), .hub_row(hub_row), .frame_start(frame_start)
  );

  always #5 clock = ~clock;

  always @(posedge clock) ram_rdata <= mem[ram_raddr];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Map a cycle index within a frame to row, plane, phase and shift step.
  function automatic void decode(input int t, output int r, output int p,
                                 output int ph, output int k);
    int rem, len;
    bit found;
    r = t / ROW_LEN;
    rem = t % ROW_LEN;
    p = 0; k = 0; found = 0;
    for (int i = 0; i < DEPTH; i++) begin
      len = PLANE_FIX + (BASE << i);
      if (!found) begin
        if (rem < len) begin p = i; found = 1; end
        else rem -= len;
      end
    end
    if (rem == 0) ph = PH_PRE;
    else if (rem <= 2 * COLS) begin ph = PH_SHIFT; k = rem - 1; end
    else if (rem == 2 * COLS + 1) ph = PH_L0;
    else if (rem == 2 * COLS + 2) ph = PH_L1;
    else ph = PH_SHOW;
  endfunction

  function automatic logic [5:0] ext(input logic [31:0] d, input int p);
    return {d[10+p], d[5+p], d[p], d[26+p], d[21+p], d[16+p]};
  endfunction

  // model advance, one step per clock
  always @(posedge clock or negedge resetn) begin
    int r, p, ph, k;
    if (!resetn) begin
      m_run = 0; m_t = 0; m_bank = 0; m_pend = 0; m_ack = 0; m_fs = 0; m_row = 0;
    end else begin
      m_ack = 0; m_fs = 0;
      if (!m_run) begin
        if (swap_req) m_pend = 1;
        if (enable) begin m_run = 1; m_t = 0; m_fs = 1; end
      end else if (m_t == FRAME - 1) begin
        if (m_pend || swap_req) begin m_bank = !m_bank; m_ack = 1; end
        m_pend = 0;
        if (enable) begin m_t = 0; m_fs = 1; end
        else m_run = 0;
      end else begin
        if (swap_req) m_pend = 1;
        m_t++;
      end
      if (m_run) begin
        decode(m_t, r, p, ph, k);
        if (ph == PH_L0) m_row = r;
      end
    end
  end

  // per-cycle comparison of every output against the model
  always @(negedge clock) begin
    int r, p, ph, k, col, idx;
    logic [13:0] e_v, g_v;
    if (chk_en) begin
      r = 0; p = 0; ph = -1; k = 0;
      if (m_run) decode(m_t, r, p, ph, k);
      e_v = {!(m_run && ph == PH_SHOW), (m_run && ph == PH_SHIFT && (k % 2) == 1),
             (m_run && ph == PH_L0), m_fs, m_ack, m_bank, RW'(m_row), ext(ram_rdata, p)};
      g_v = {hub_oe, hub_ck, hub_st, frame_start, swap_ack, display_bank, hub_row, hub_rgb};
      chk("outs", g_v, e_v);
      if (m_run && ph == PH_PRE)
        chk("raddr_pre", ram_raddr, (m_bank << (RW + CW)) | (r << CW));
      if (m_run && ph == PH_SHIFT) begin
        col = (k + 1) / 2;
        if (col > COLS - 1) col = COLS - 1;
        chk("raddr_shift", ram_raddr, (m_bank << (RW + CW)) | (r << CW) | col);
        idx = (m_bank << (RW + CW)) | (r << CW) | (k / 2);
        chk("rdata_col", ram_rdata, mem[idx]);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    #2 resetn = 1'b0;
    tick(2);
  endtask

  task automatic wait_frame_end();
    int i = 0;
    bit ok = 0;
    while (!ok && i < 2 * FRAME + 20) begin
      @(negedge clock);
      i++;
      if (m_run && m_t == FRAME - 1) ok = 1;
    end
    if (!ok) chk("timeout_frame_end", 0, 1);
  endtask

  task automatic wait_fs();
    int i = 0;
    bit ok = 0;
    while (!ok && i < 2 * FRAME + 20) begin
      @(negedge clock);
      i++;
      if (frame_start) ok = 1;
    end
    if (!ok) chk("timeout_frame_start", 0, 1);
  endtask

  initial begin
    int r, p, ph, k;
    int fs1, fs2, run, ck_rise, st_cnt, acks, oe_low, fs_cnt, guard;
    bit prev_ck, ok;
    int runs[$];

    for (int a = 0; a < (1 << AW); a++) mem[a] = 32'h7FFF_0000;
    #1 resetn = 1'b0;
    chk_en = 1'b1;
    tick(3);
    chk("rst_oe", hub_oe, 1);
    chk("rst_ck", hub_ck, 0);
    chk("rst_st", hub_st, 0);
    chk("rst_row", hub_row, 0);
    chk("rst_raddr", ram_raddr, 0);
    chk("rst_bank", display_bank, 0);
    chk("rst_ack", swap_ack, 0);
    chk("rst_fs", frame_start, 0);

    // first frame: timing of row 0 and frame period
    enable = 1'b1;
    resetn = 1'b1;
    fs1 = -1; fs2 = -1; run = 0; ck_rise = 0; st_cnt = 0; prev_ck = 0;
    for (int c = 0; c < FRAME + ROW_LEN; c++) begin
      @(negedge clock);
      if (frame_start) begin
        if (fs1 < 0) fs1 = c;
        else if (fs2 < 0) fs2 = c;
      end
      if (fs1 >= 0 && (c - fs1) <= ROW_LEN) begin
        if (!hub_oe) run++;
        else if (run > 0) begin runs.push_back(run); run = 0; end
        if ((c - fs1) < PLANE_FIX) begin
          if (hub_ck && !prev_ck) ck_rise++;
          if (hub_st) st_cnt++;
        end
        if (m_run) begin
          decode(m_t, r, p, ph, k);
          if (ph == PH_SHIFT) chk("fill_rgb", hub_rgb, 6'b000111);
        end
      end
      prev_ck = hub_ck;
    end
    chk("fs_first", fs1, 0);
    chk("frame_len", fs2 - fs1, FRAME);
    chk("plane_runs", runs.size(), DEPTH);
    for (int q = 0; q < DEPTH; q++)
      chk("oe_low_plane", (q < runs.size()) ? runs[q] : -1, BASE << q);
    chk("ck_rises", ck_rise, COLS);
    chk("st_pulses", st_cnt, 1);

    // single low-half blue LSB: visible only in plane 0
    do_reset();
    for (int a = 0; a < (1 << AW); a++) mem[a] = 32'h0000_0001;
    resetn = 1'b1;
    for (int c = 0; c < ROW_LEN; c++) begin
      @(negedge clock);
      if (m_run) begin
        decode(m_t, r, p, ph, k);
        if (ph == PH_SHIFT) chk("b1_rgb", hub_rgb, (p == 0) ? 6'b001000 : 6'b000000);
      end
    end

    // mid-frame swap requests (two in one frame) give one toggle
    do_reset();
    for (int a = 0; a < (1 << AW); a++) mem[a] = $urandom;
    resetn = 1'b1;
    tick(FRAME / 3);
    swap_req = 1'b1; tick(1); swap_req = 1'b0;
    chk("bank_hold", display_bank, 0);
    tick(FRAME / 4);
    swap_req = 1'b1; tick(1); swap_req = 1'b0;
    chk("bank_hold2", display_bank, 0);
    acks = 0; ok = 0; guard = 0;
    while (!ok && guard < FRAME + 20) begin
      @(negedge clock);
      guard++;
      if (swap_ack) acks++;
      if (frame_start) ok = 1;
    end
    chk("swap_fs_seen", ok, 1);
    chk("swap_ack_at_fs", swap_ack, 1);
    chk("bank_after", display_bank, 1);
    chk("raddr_msb", ram_raddr[AW-1], 1);
    for (int c = 0; c < ROW_LEN; c++) begin
      @(negedge clock);
      if (swap_ack) acks++;
    end
    chk("ack_count", acks, 1);

    // request in the frame-end cycle is taken at that boundary
    wait_frame_end();
    swap_req = 1'b1; tick(1); swap_req = 1'b0;
    chk("coinc_ack", swap_ack, 1);
    chk("coinc_bank", display_bank, 0);

    // request one cycle after frame end waits a whole frame
    wait_frame_end();
    tick(1);
    chk("late_pre_ack", swap_ack, 0);
    swap_req = 1'b1; tick(1); swap_req = 1'b0;
    chk("late_noack", swap_ack, 0);
    chk("late_bank", display_bank, 0);
    wait_fs();
    chk("late_ack", swap_ack, 1);
    chk("late_bank2", display_bank, 1);

    // randomized swap requests and enable toggles
    for (int c = 0; c < 6 * FRAME; c++) begin
      @(negedge clock);
      swap_req = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 1999) == 0) enable = ~enable;
    end
    swap_req = 1'b0;
    enable = 1'b1;

    // async reset while showing a non-zero row
    ok = 0; guard = 0;
    while (!ok && guard < 2 * FRAME + 20) begin
      @(negedge clock);
      guard++;
      if (!hub_oe && hub_row != 0) ok = 1;
    end
    chk("show_found", ok, 1);
    #2 resetn = 1'b0;
    #1;
    chk("arst_oe", hub_oe, 1);
    chk("arst_row", hub_row, 0);
    chk("arst_raddr", ram_raddr, 0);
    chk("arst_bank", display_bank, 0);
    tick(2);
    resetn = 1'b1;
    tick(1);
    chk("restart_fs", frame_start, 1);
    chk("restart_raddr", ram_raddr, 0);

    // enable dropped mid-frame: frame completes, then idle and blanked
    tick(FRAME / 2);
    enable = 1'b0;
    ok = 0; guard = 0;
    while (!ok && guard < 2 * FRAME + 20) begin
      @(negedge clock);
      guard++;
      if (!m_run) ok = 1;
    end
    chk("idle_reached", ok, 1);
    chk("idle_after_full", guard > FRAME / 2 - 5, 1);
    oe_low = 0; fs_cnt = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clock);
      if (!hub_oe) oe_low++;
      if (frame_start) fs_cnt++;
    end
    chk("idle_oe_low", oe_low, 0);
    chk("idle_fs", fs_cnt, 0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
